// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: queued fetch entries and fetch FSM states.
package fetch_pkg;

   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      WAIT_MEM,
      RUN,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries with push/pop/flush and an occupancy count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          HCLK,
   input  logic                          HRESET,
   input  logic                          push,
   input  fetch_entry_t                  push_data,
   input  logic                          pop,
   input  logic                          flush,
   output fetch_entry_t                  head,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   fetch_entry_t   mem [FIFO_DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;

   // Storage is cleared on reset so the head reads as zero before the first push.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding a one-cycle-latency word SRAM into a prefetch FIFO.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky fetch_fault and halt issue.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0]  RESET_PC   = 32'h0000_0000,
   parameter int unsigned  FIFO_DEPTH = 4
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   output logic        fetch_fault
);

   localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] STEP = 32'(INSTR_BYTES);

   fetch_state_t  state;
   logic [31:0]   fetch_pc;
   logic [31:0]   next_pc;
   logic [31:0]   rsp_pc;
   logic          rsp_pending;
   logic [31:0]   aligned_pc;
   logic [31:0]   redir_pc;
   logic          fire;
   logic          push;
   logic          pop;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   fetch_entry_t  push_data;

   assign aligned_pc = redirect_pc & ~32'd3;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;
   logic misalign;
   assign misalign    = redirect_pc[1:0] != 2'b00;
   assign redir_pc    = redirect_pc;
   assign fetch_fault = fault_q;
`else
   assign redir_pc    = aligned_pc;
   assign fetch_fault = 1'b0;
`endif

   // Credit counts the in-flight response so a capture can never overflow the FIFO.
   assign fire = (state == RUN) && mem_ready && !redirect_valid &&
                 ((32'(count) + 32'(rsp_pending)) < FIFO_DEPTH);
   assign next_pc   = fetch_pc + STEP;
   assign push      = rsp_pending && !redirect_valid;
   assign pop       = instr_valid && instr_ready && !redirect_valid;
   assign push_data = '{pc: rsp_pc, instr: mem_rdata};

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state       <= WAIT_MEM;
         fetch_pc    <= RESET_PC;
         mem_addr    <= {2'b00, RESET_PC[31:2]};
         rsp_pc      <= '0;
         rsp_pending <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         rsp_pending <= fire;
         if (fire) begin
            rsp_pc <= fetch_pc;
         end
         if (redirect_valid) begin
            if (state == WAIT_MEM) begin
               fetch_pc <= aligned_pc;
               mem_addr <= {2'b00, aligned_pc[31:2]};
               if (mem_ready) begin
                  state <= RUN;
               end
            end else begin
               fetch_pc <= redir_pc;
               mem_addr <= {2'b00, redir_pc[31:2]};
`ifdef FETCH_MISALIGN_TRAP_EN
               state    <= misalign ? HALT : RUN;
               fault_q  <= misalign;
`else
               state    <= RUN;
`endif
            end
         end else if (fire) begin
            fetch_pc <= next_pc;
            mem_addr <= {2'b00, next_pc[31:2]};
         end else if ((state == WAIT_MEM) && mem_ready) begin
            state <= RUN;
         end
      end
   end

   fetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .count     (count)
   );

   assign instr_valid = (count != '0);
   assign instr_data  = head.instr;
   assign instr_pc    = head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   if_fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .HCLK           (HCLK),
      .HRESET         (HRESET),
      .mem_ready      (mem_ready),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 HCLK = ~HCLK;

   // SRAM contents: word i holds 0x100 + i.
   always @(posedge HCLK) mem_rdata <= 32'h100 + mem_addr;

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return 32'h100 + (pc >> 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of pcs awaiting decode, one pending response, next fetch pc.
   logic [31:0] q[$];
   bit          m_run, m_halt, m_pend, m_fault;
   logic [31:0] m_fpc, m_ppc;

   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         q.delete();
         m_run = 0; m_halt = 0; m_pend = 0; m_fault = 0;
         m_fpc = RESET_PC; m_ppc = '0;
      end else begin
         bit can_issue;
         can_issue = m_run && !m_halt && mem_ready && ((q.size() + int'(m_pend)) < DEPTH);
         if (redirect_valid) begin
            q.delete();
            m_pend = 0;
            if (!m_run) begin
               m_fpc = redirect_pc & ~32'd3;
               if (mem_ready) m_run = 1;
            end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
               m_fault = (redirect_pc[1:0] != 2'b00);
               m_halt  = m_fault;
               m_fpc   = redirect_pc;
`else
               m_fpc   = redirect_pc & ~32'd3;
`endif
            end
         end else begin
            if (instr_ready && q.size() > 0) void'(q.pop_front());
            if (m_pend) q.push_back(m_ppc);
            if (can_issue) begin
               m_ppc = m_fpc;
               m_fpc = m_fpc + 32'd4;
            end
            m_pend = can_issue;
            if (mem_ready) m_run = 1;
         end
      end
   end

   always @(negedge HCLK) begin
      if (!HRESET) begin
         chk("mem_addr", mem_addr, m_fpc >> 2);
         chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
         if (q.size() > 0) begin
            chk("instr_pc", instr_pc, q[0]);
            chk("instr_data", instr_data, word_at(q[0]));
         end
         chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      end
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      redirect_valid = 1'b0;
      mem_ready = 1'b0;
      step();
      step();
      HRESET = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!instr_valid && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (!instr_valid) begin
         errors++;
         $display("FAIL %s: instr_valid got 0 expected 1 within 20 cycles", name);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // 1: reset values, idle with memory not ready, then sequential addresses
      #1;
      chk("rst_addr", mem_addr, RESET_PC >> 2);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_data", instr_data, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      do_reset();
      instr_ready = 1'b1;
      repeat (5) begin
         step();
         chk("t1_addr_idle", mem_addr, 32'd0);
         chk("t1_valid_idle", 32'(instr_valid), 32'd0);
      end
      mem_ready = 1'b1;
      step(); chk("t1_addr0", mem_addr, 32'd0);
      step(); chk("t1_addr1", mem_addr, 32'd1);
      step(); chk("t1_addr2", mem_addr, 32'd2);

      // 2: one instruction per cycle in program order
      for (int i = 0; i < 8; i++) begin
         chk("t2_valid", 32'(instr_valid), 32'd1);
         chk("t2_pc", instr_pc, 32'(4 * i));
         chk("t2_data", instr_data, 32'h100 + 32'(i));
         step();
      end

      // 3: back-pressure fills exactly DEPTH entries, then drains in order
      do_reset();
      instr_ready = 1'b0;
      mem_ready = 1'b1;
      repeat (10) step();
      chk("t3_addr_stall", mem_addr, 32'd4);
      chk("t3_valid", 32'(instr_valid), 32'd1);
      chk("t3_head", instr_pc, 32'd0);
      instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t3_drain_valid", 32'(instr_valid), 32'd1);
         chk("t3_drain_pc", instr_pc, 32'(4 * i));
         chk("t3_drain_data", instr_data, 32'h100 + 32'(i));
         step();
      end

      // 4: redirect with three queued and one in flight
      do_reset();
      instr_ready = 1'b0;
      mem_ready = 1'b1;
      repeat (5) step();
      chk("t4_head_before", instr_pc, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      instr_ready = 1'b1;
      chk("t4_flushed", 32'(instr_valid), 32'd0);
      chk("t4_addr", mem_addr, 32'h10);
      wait_valid("t4_wait");
      chk("t4_pc", instr_pc, 32'h40);
      chk("t4_data", instr_data, 32'h110);

      // 5: redirect coinciding with a pop, then reset mid-stream
      repeat (4) step();
      chk("t5_streaming", 32'(instr_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect_valid = 1'b0;
      chk("t5_flushed", 32'(instr_valid), 32'd0);
      wait_valid("t5_wait");
      chk("t5_pc", instr_pc, 32'h200);
      chk("t5_data", instr_data, 32'h180);
      repeat (3) step();
      HRESET = 1'b1;
      #1;
      chk("t5_rst_addr", mem_addr, RESET_PC >> 2);
      chk("t5_rst_valid", 32'(instr_valid), 32'd0);
      step();
      HRESET = 1'b0;

`ifdef FETCH_MISALIGN_TRAP_EN
      // 6: misaligned redirect traps, next aligned redirect resumes
      do_reset();
      mem_ready = 1'b1;
      instr_ready = 1'b1;
      repeat (6) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h42;
      step();
      redirect_valid = 1'b0;
      chk("t6_fault", 32'(fetch_fault), 32'd1);
      chk("t6_valid", 32'(instr_valid), 32'd0);
      repeat (5) step();
      chk("t6_halt_addr", mem_addr, 32'h10);
      chk("t6_halt_valid", 32'(instr_valid), 32'd0);
      chk("t6_sticky", 32'(fetch_fault), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h80;
      step();
      redirect_valid = 1'b0;
      chk("t6_clear", 32'(fetch_fault), 32'd0);
      wait_valid("t6_wait");
      chk("t6_pc", instr_pc, 32'h80);
      chk("t6_data", instr_data, 32'h120);
`endif

      // Randomized traffic, checked every cycle by the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         mem_ready      = ($urandom_range(0, 9) != 0);
         instr_ready    = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = 32'($urandom_range(0, 1023));
         HRESET         = ($urandom_range(0, 599) == 0);
         step();
      end
      HRESET = 1'b0;
      redirect_valid = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
